// File: rtl/imm_pkg.sv
// Shared types, opcode constants and the opcode-to-format map for the
// pipelined immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_NONE = 3'b101,
    IMM_ILL0 = 3'b110,
    IMM_ILL1 = 3'b111
  } imm_fmt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Unmapped opcodes fold onto IMM_ILL0 so the extractor flags them.
  function automatic imm_fmt_t fmt_from_opcode(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
      OP_STORE:                            fmt = IMM_S;
      OP_BRANCH:                           fmt = IMM_B;
      OP_JAL:                              fmt = IMM_J;
      OP_LUI, OP_AUIPC:                    fmt = IMM_U;
      OP_REG:                              fmt = IMM_NONE;
      default:                             fmt = IMM_ILL0;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  logic signed [31:0] imm32;

  // Build a sign-extended 32-bit immediate; the signed cast widens it for XLEN=64.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (fmt)
      IMM_I:    imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
      IMM_J:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
      IMM_U:    imm32 = {instr[31:12], 12'b0};
      IMM_NONE: imm32 = '0;
      default:  illegal = 1'b1;
    endcase
  end

  assign immext = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format select, extraction, and a
// 2-entry skid buffer behind a valid/ready handshake.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic [2:0]      out_immsrc,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  skid_state_t     state, next_state;
  imm_fmt_t        fmt_sel;
  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;
  logic            accept, drain;
  logic            load_main_in, load_main_skid, load_skid;

  logic [XLEN-1:0] main_data, skid_data;
  imm_fmt_t        main_fmt, skid_fmt;
  logic            main_ill, skid_ill;

  assign fmt_sel = AUTO_DECODE ? fmt_from_opcode(instr[6:0]) : imm_fmt_t'(immsrc);

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (instr),
    .fmt     (fmt_sel),
    .immext  (ext_data),
    .illegal (ext_illegal)
  );

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SKID_EMPTY;
    else     state <= next_state;
  end

  // Flush wins over everything: buffered and same-cycle inputs are dropped.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (accept) begin
            next_state   = SKID_ONE;
            load_main_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            next_state = SKID_FULL;
            load_skid  = 1'b1;
          end else if (drain) begin
            next_state = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            next_state     = SKID_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: next_state = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_fmt  <= IMM_I;
      main_ill  <= 1'b0;
      skid_data <= '0;
      skid_fmt  <= IMM_I;
      skid_ill  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= ext_data;
        main_fmt  <= fmt_sel;
        main_ill  <= ext_illegal;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_fmt  <= skid_fmt;
        main_ill  <= skid_ill;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_fmt  <= fmt_sel;
        skid_ill  <= ext_illegal;
      end
    end
  end

  assign immext      = main_data;
  assign out_immsrc  = main_fmt;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (32-bit, 64-bit,
// 32-bit auto-decode) share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        rdya, vlda, illa;
  logic [31:0] imma;
  logic [2:0]  fmta;

  int check_count = 0;
  int pass_count  = 0;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .immsrc(immsrc), .out_valid(vld32), .out_ready(out_ready),
    .immext(imm32), .out_immsrc(fmt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .immsrc(immsrc), .out_valid(vld64), .out_ready(out_ready),
    .immext(imm64), .out_immsrc(fmt64), .out_illegal(ill64)
  );

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) duta (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdya),
    .instr(instr), .immsrc(immsrc), .out_valid(vlda), .out_ready(out_ready),
    .immext(imma), .out_immsrc(fmta), .out_illegal(illa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [2:0] s,
                               input logic r, input logic f);
    in_valid  = v;
    instr     = i;
    immsrc    = s;
    out_ready = r;
    flush     = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    #2;
    checkOutput("reset out_valid", 64'(vld32), 64'd0);
    checkOutput("reset in_ready", 64'(rdy32), 64'd1);
    checkOutput("reset immext32", 64'(imm32), 64'd0);
    checkOutput("reset immext64", imm64, 64'd0);
    checkOutput("reset out_immsrc", 64'(fmt32), 64'd0);
    checkOutput("reset out_illegal", 64'(ill32), 64'd0);
    #1 rst = 1'b0;
    step();

    // I-type, all-ones immediate
    applyStimulus(1'b1, 32'hFFF00093, 3'b000, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("I out_valid", 64'(vld32), 64'd1);
    checkOutput("I immext32", 64'(imm32), 64'hFFFFFFFF);
    checkOutput("I immext64", imm64, 64'hFFFFFFFFFFFFFFFF);
    checkOutput("I auto fmt", 64'(fmta), 64'd0);
    step();
    checkOutput("I drained", 64'(vld32), 64'd0);

    // B then S then U back-to-back
    applyStimulus(1'b1, 32'hFE000EE3, 3'b010, 1'b1, 1'b0);
    step();
    checkOutput("B immext32", 64'(imm32), 64'hFFFFFFFC);
    checkOutput("B immext64", imm64, 64'hFFFFFFFFFFFFFFFC);
    checkOutput("B auto fmt", 64'(fmta), 64'd2);
    applyStimulus(1'b1, 32'hFE112C23, 3'b001, 1'b1, 1'b0);
    step();
    checkOutput("S immext32", 64'(imm32), 64'hFFFFFFF8);
    checkOutput("S auto fmt", 64'(fmta), 64'd1);
    checkOutput("S auto immext", 64'(imma), 64'hFFFFFFF8);
    applyStimulus(1'b1, 32'h123450B7, 3'b100, 1'b1, 1'b0);
    step();
    checkOutput("U pos immext64", imm64, 64'h0000000012345000);
    checkOutput("U pos immext32", 64'(imm32), 64'h12345000);
    applyStimulus(1'b1, 32'h800000B7, 3'b100, 1'b1, 1'b0);
    step();
    checkOutput("U neg immext64", imm64, 64'hFFFFFFFF80000000);
    checkOutput("U neg auto fmt", 64'(fmta), 64'd4);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    step();
    checkOutput("U drained", 64'(vld32), 64'd0);

    // A, B, C with downstream stalled for three edges
    applyStimulus(1'b1, 32'h00100093, 3'b000, 1'b0, 1'b0);
    step();
    checkOutput("stall A valid", 64'(vld32), 64'd1);
    checkOutput("stall A data", 64'(imm32), 64'd1);
    applyStimulus(1'b1, 32'h00200093, 3'b000, 1'b0, 1'b0);
    step();
    checkOutput("stall full in_ready", 64'(rdy32), 64'd0);
    checkOutput("stall A held", 64'(imm32), 64'd1);
    applyStimulus(1'b1, 32'h00300093, 3'b000, 1'b0, 1'b0);
    step();
    checkOutput("stall C blocked", 64'(rdy32), 64'd0);
    checkOutput("stall A still", 64'(imm64), 64'd1);
    applyStimulus(1'b1, 32'h00300093, 3'b000, 1'b1, 1'b0);
    step();
    checkOutput("drain B data", 64'(imm32), 64'd2);
    checkOutput("drain in_ready", 64'(rdy32), 64'd1);
    step();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("drain C data", 64'(imm32), 64'd3);
    checkOutput("drain C valid", 64'(vld32), 64'd1);
    step();
    checkOutput("drain empty", 64'(vld32), 64'd0);

    // Flush from FULL with a word offered
    applyStimulus(1'b1, 32'h00400093, 3'b000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h00500093, 3'b000, 1'b0, 1'b0);
    step();
    checkOutput("pre-flush full", 64'(rdy32), 64'd0);
    applyStimulus(1'b1, 32'h00600093, 3'b000, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("flush out_valid", 64'(vld32), 64'd0);
    checkOutput("flush in_ready", 64'(rdy32), 64'd1);
    step();
    checkOutput("flush stays empty", 64'(vld64), 64'd0);

    // Input accepted during flush is dropped; next word goes through
    applyStimulus(1'b1, 32'h00800093, 3'b000, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    checkOutput("flush drop valid", 64'(vld32), 64'd0);
    applyStimulus(1'b1, 32'h00700093, 3'b000, 1'b1, 1'b0);
    step();
    checkOutput("post-flush valid", 64'(vld32), 64'd1);
    checkOutput("post-flush data", 64'(imm32), 64'd7);

    // NONE format and illegal formats
    applyStimulus(1'b1, 32'hFFF00093, 3'b101, 1'b1, 1'b0);
    step();
    checkOutput("NONE immext", 64'(imm32), 64'd0);
    checkOutput("NONE illegal", 64'(ill32), 64'd0);
    checkOutput("NONE fmt", 64'(fmt32), 64'd5);
    applyStimulus(1'b1, 32'h00000000, 3'b110, 1'b1, 1'b0);
    step();
    checkOutput("ILL illegal", 64'(ill32), 64'd1);
    checkOutput("ILL immext", 64'(imm32), 64'd0);
    checkOutput("ILL auto illegal", 64'(illa), 64'd1);
    applyStimulus(1'b1, 32'hFFF00093, 3'b111, 1'b1, 1'b0);
    step();
    checkOutput("ILL1 illegal", 64'(ill64), 64'd1);
    checkOutput("ILL1 immext", imm64, 64'd0);
    checkOutput("ILL1 auto legal", 64'(illa), 64'd0);

    // Asynchronous reset between edges while FULL
    applyStimulus(1'b1, 32'h00100093, 3'b000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h00200093, 3'b000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    checkOutput("pre-rst valid", 64'(vld32), 64'd1);
    checkOutput("pre-rst in_ready", 64'(rdy32), 64'd0);
    #3 rst = 1'b1;
    #1;
    checkOutput("async rst valid", 64'(vld32), 64'd0);
    checkOutput("async rst in_ready", 64'(rdy32), 64'd1);
    checkOutput("async rst immext", imm64, 64'd0);
    #2 rst = 1'b0;
    step();
    checkOutput("post-rst valid", 64'(vld32), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
